// File: rtl/reg_loader_pkg.sv
// Shared definitions for the register-file loader: FSM encoding, register
// range and datapath widths.
package reg_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;

    localparam logic [ADDR_W-1:0] FIRST_REG = 5'd1;
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(REG_COUNT - 1);

endpackage

// File: rtl/reg_loader.sv
// Streams 31 words into registers 1..31 of a register file, tracking an XOR checksum.
// Readback verification against the checksum is compiled in with REG_LOADER_VERIFY_EN.
module reg_loader
    import reg_loader_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              In_Valid,
    input  logic [DATA_W-1:0] In_Data,
    output logic              In_Ready,
    output logic [ADDR_W-1:0] Awr,
    output logic [DATA_W-1:0] Din,
    output logic              WrEn,
    output logic [ADDR_W-1:0] Ard1,
    input  logic [DATA_W-1:0] Dout1,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] Checksum
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_wren;
    logic              r_done;
    logic [ADDR_W-1:0] r_awr;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_checksum;
    logic              w_accept;

`ifdef REG_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] r_vaddr;
    logic [DATA_W-1:0] r_sum;
    logic              r_err;
`else
    logic              w_unused_dout;
`endif

    assign w_accept = In_Valid && r_in_ready;

    // Loader FSM; write port, status and accumulators are all registered here.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= 5'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_wren     <= 1'b0;
            r_done     <= 1'b0;
            r_awr      <= 5'd0;
            r_din      <= 32'h0000_0000;
            r_checksum <= 32'h0000_0000;
`ifdef REG_LOADER_VERIFY_EN
            r_vaddr    <= 5'd0;
            r_sum      <= 32'h0000_0000;
            r_err      <= 1'b0;
`endif
        end else begin
            r_wren <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_state    <= ST_LOAD;
                        r_addr     <= FIRST_REG;
                        r_checksum <= 32'h0000_0000;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef REG_LOADER_VERIFY_EN
                        r_sum      <= 32'h0000_0000;
                        r_err      <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_wren     <= 1'b1;
                        r_awr      <= r_addr;
                        r_din      <= In_Data;
                        r_checksum <= r_checksum ^ In_Data;
                        // The address counter parks at the last register instead of wrapping.
                        if (r_addr == LAST_REG) begin
                            r_in_ready <= 1'b0;
`ifdef REG_LOADER_VERIFY_EN
                            r_state    <= ST_VERIFY;
                            r_vaddr    <= FIRST_REG;
`else
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
`endif
                        end else begin
                            r_addr <= r_addr + 5'd1;
                        end
                    end
                end
`ifdef REG_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    r_sum <= r_sum ^ Dout1;
                    if (r_vaddr == LAST_REG) begin
                        r_vaddr <= 5'd0;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_vaddr <= r_vaddr + 5'd1;
                    end
                end
`endif
                ST_DONE: begin
`ifdef REG_LOADER_VERIFY_EN
                    r_err   <= (r_sum != r_checksum);
`endif
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign In_Ready = r_in_ready;
    assign Awr      = r_awr;
    assign Din      = r_din;
    assign WrEn     = r_wren;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Checksum = r_checksum;

`ifdef REG_LOADER_VERIFY_EN
    assign Ard1 = r_vaddr;
    assign Err  = r_err;
`else
    assign Ard1          = 5'd0;
    assign Err           = 1'b0;
    assign w_unused_dout = ^Dout1;
`endif

endmodule

// File: doc/reg_loader.md
REG_LOADER -- requirements
Module: reg_loader

Interface
REQ-001 SHALL have ports, clock and reset first: Clk in 1, rising-edge clock; Rst in 1, synchronous active-high reset.
REQ-002 SHALL have Start in 1, one-cycle request to begin a load; ignored unless IDLE.
REQ-003 SHALL have In_Valid in 1, In_Data in 32, In_Ready out 1: load-word stream, word accepted when In_Valid && In_Ready at a rising Clk edge.
REQ-004 SHALL have Awr out 5, Din out 32, WrEn out 1: register-file write port, all registered.
REQ-005 SHALL have Ard1 out 5 (register-file read address) and Dout1 in 32 (register-file read data, combinational from Ard1).
REQ-006 SHALL have Busy out 1, Done out 1 (one-cycle pulse), Err out 1 (sticky), Checksum out 32 (XOR of all accepted words).

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, VERIFY, DONE.
REQ-008 IDLE: Start=1 -> LOAD, address counter := 1, Checksum := 0, Err := 0.
REQ-009 Register 0 SHALL never be written; LOAD covers addresses 1..31 (31 words) in ascending order.
REQ-010 LOAD: In_Ready = 1; all other states In_Ready = 0.
REQ-011 On acceptance at edge N: cycle after N drives WrEn=1, Awr=counter, Din=In_Data (1-cycle latency); counter++; Checksum ^= In_Data.
REQ-012 Cycles with no acceptance SHALL drive WrEn=0 on the next cycle; In_Valid gaps of any length are allowed.
REQ-013 Acceptance at address 31 SHALL leave LOAD (-> VERIFY if enabled, else DONE); counter SHALL not wrap to 0.
REQ-014 VERIFY: Ard1 = verify counter starting at 1; each cycle XOR Dout1 into readback sum, counter++; after address 31 -> DONE (exactly 31 VERIFY cycles).
REQ-015 The write of register 31 (WrEn high in first VERIFY cycle) SHALL commit before register 31 is read.
REQ-016 DONE: Done=1 for one cycle; Err := (readback sum != Checksum); -> IDLE.
REQ-017 Busy = 1 in LOAD, VERIFY and DONE; 0 in IDLE.
REQ-018 Ard1 SHALL be 0 outside VERIFY.
REQ-019 Start during LOAD, VERIFY or DONE SHALL be ignored with no effect.
REQ-020 Err and Checksum SHALL hold their values in IDLE until the next accepted Start.

Reset
REQ-021 Rst=1 at an edge SHALL force IDLE; WrEn=0, Awr=0, Din=0, Ard1=0, Busy=0, Done=0, Err=0, Checksum=0, counters=0, In_Ready=0.
REQ-022 Rst during LOAD or VERIFY SHALL abort with no further writes after the reset edge; no Done pulse; already-committed register writes are not undone.

Configuration
REQ-023 Macro REG_LOADER_VERIFY_EN defined: VERIFY state and readback compare SHALL be compiled in.
REQ-024 Macro undefined: LOAD -> DONE directly after address 31; Ard1 tied 0; Err tied 0; Checksum still computed.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, REG_COUNT=32, FIRST_REG=1, LAST_REG=31 and the data/address widths (32/5).
REQ-026 No sub-module; a single module containing the FSM, counters and XOR accumulators.

Verification
REQ-027 Bench SHALL pair reg_loader with the existing register file (Clk, Rst, WrEn, Awr, Din, Ard1, Dout1 connected).
REQ-028 Stream words 0x100+i for i=1..31, In_Valid held high -> WrEn high 31 consecutive cycles with Awr 1..31; register i reads 0x100+i; register 0 reads 0; Checksum matches the XOR of all 31 words; Done pulses once; Err=0.
REQ-029 Same stream with In_Valid low every other cycle -> identical register contents and Checksum; WrEn low in every cycle following an idle input cycle.
REQ-030 Force register-file write of register 17 to 0xDEADBEEF during VERIFY, before address 17 is read (VERIFY_EN) -> Err=1 after Done; Err stays 1 in IDLE.
REQ-031 Assert Rst after 10 accepted words -> WrEn=0 from the next cycle; Busy=0; no Done pulse; registers 1..10 keep their values; new Start reloads from address 1.
REQ-032 Pulse Start in LOAD after 5 words and again in VERIFY -> no restart; counters unaffected; single Done pulse.
REQ-033 Build without REG_LOADER_VERIFY_EN -> Done occurs 1 cycle after the last acceptance; Ard1 stays 0; Err stays 0.
